// File: rtl/fp_align_pkg.sv
// ============================================================================
// Module : fp_align_pkg
// Brief  : Shared constants and helpers for the FP alignment shifter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_align_pkg;

    localparam int GRS_W     = 2;   // guard + round bits appended below the mantissa
    localparam int SP_MANT_W = 24;
    localparam int DP_MANT_W = 53;

    // Shift amounts at or above this value flush the whole mantissa into sticky.
    function automatic int sat_threshold(input int mant_w);
        return mant_w + GRS_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_rshift_sticky_level.sv
// ============================================================================
// Module : fp_rshift_sticky_level
// Brief  : One log-shifter level: conditional right shift by AMT with sticky OR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_rshift_sticky_level #(
    parameter int W   = 26,
    parameter int AMT = 1
) (
    input  logic [W-1:0] vec_in,
    input  logic         sticky_in,
    input  logic         ena,
    output logic [W-1:0] vec_out,
    output logic         sticky_out
);

    logic w_disc;

    generate
        if (AMT >= W) begin : g_sat
            // The whole vector falls off the bottom.
            assign vec_out = ena ? '0 : vec_in;
            assign w_disc  = |vec_in;
        end else begin : g_shift
            assign vec_out = ena ? (vec_in >> AMT) : vec_in;
            assign w_disc  = |vec_in[AMT-1:0];
        end
    endgenerate

    assign sticky_out = sticky_in | (ena & w_disc);

endmodule

`default_nettype wire

// File: rtl/fp_align_rshift_pipe.sv
// ============================================================================
// Module : fp_align_rshift_pipe
// Brief  : Two-stage elastic mantissa right-shift aligner with guard/round/sticky.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_align_rshift_pipe
    import fp_align_pkg::*;
#(
    parameter int MANT_W  = SP_MANT_W,
    parameter int SHIFT_W = 5,
    parameter int TAG_W   = 4,
    parameter int SPLIT   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [MANT_W-1:0]  in_mant,
    input  logic [SHIFT_W-1:0] in_nshift,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [MANT_W-1:0]  out_mant,
    output logic               out_guard,
    output logic               out_round,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int EXT_W = sat_threshold(MANT_W);
    localparam int LO_W  = SHIFT_W - SPLIT;

    // ---------------- handshake ----------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv && !flush;
    assign w_accept = in_valid && in_ready;

    // ---------------- stage-1 shift levels (MSB levels) ----------------
    logic [EXT_W-1:0] w_s1_vec [0:SPLIT];
    logic             w_s1_stk [0:SPLIT];

    assign w_s1_vec[0] = {in_mant, {GRS_W{1'b0}}};
    assign w_s1_stk[0] = 1'b0;

    generate
        for (genvar j = 0; j < SPLIT; j++) begin : g_s1_lvl
            localparam int LVL = SHIFT_W - 1 - j;
            fp_rshift_sticky_level #(
                .W   (EXT_W),
                .AMT (1 << LVL)
            ) u_lvl (
                .vec_in     (w_s1_vec[j]),
                .sticky_in  (w_s1_stk[j]),
                .ena        (in_nshift[LVL]),
                .vec_out    (w_s1_vec[j+1]),
                .sticky_out (w_s1_stk[j+1])
            );
        end
    endgenerate

    logic [EXT_W-1:0] r_s1_vec;
    logic             r_s1_sticky;
    logic [LO_W-1:0]  r_s1_nlow;
    logic             r_s1_sign;
    logic [TAG_W-1:0] r_s1_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_vec    <= '0;
            r_s1_sticky <= 1'b0;
            r_s1_nlow   <= '0;
            r_s1_sign   <= 1'b0;
            r_s1_tag    <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_vec    <= w_s1_vec[SPLIT];
                r_s1_sticky <= w_s1_stk[SPLIT];
                r_s1_nlow   <= in_nshift[LO_W-1:0];
                r_s1_sign   <= in_sign;
                r_s1_tag    <= in_tag;
            end
        end
    end

    // ---------------- stage-2 shift levels (LSB levels) ----------------
    logic [EXT_W-1:0] w_s2_vec [0:LO_W];
    logic             w_s2_stk [0:LO_W];
    logic [EXT_W-1:0] w_s2_res;

    assign w_s2_vec[0] = r_s1_vec;
    assign w_s2_stk[0] = r_s1_sticky;

    generate
        for (genvar j = 0; j < LO_W; j++) begin : g_s2_lvl
            localparam int LVL = LO_W - 1 - j;
            fp_rshift_sticky_level #(
                .W   (EXT_W),
                .AMT (1 << LVL)
            ) u_lvl (
                .vec_in     (w_s2_vec[j]),
                .sticky_in  (w_s2_stk[j]),
                .ena        (r_s1_nlow[LVL]),
                .vec_out    (w_s2_vec[j+1]),
                .sticky_out (w_s2_stk[j+1])
            );
        end
    endgenerate

    assign w_s2_res = w_s2_vec[LO_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            out_mant   <= '0;
            out_guard  <= 1'b0;
            out_round  <= 1'b0;
            out_sticky <= 1'b0;
            out_sign   <= 1'b0;
            out_tag    <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_mant   <= w_s2_res[EXT_W-1:GRS_W];
                out_guard  <= w_s2_res[1];
                out_round  <= w_s2_res[0];
                out_sticky <= w_s2_stk[LO_W];
                out_sign   <= r_s1_sign;
                out_tag    <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_fp_align_rshift_pipe.sv
// ============================================================================
// Module : tb_fp_align_rshift_pipe
// Brief  : Scoreboard bench for the single- and double-width aligner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_align_rshift_pipe;

    typedef struct packed {
        logic [63:0] mant;
        logic [7:0]  n;
        logic [63:0] emant;
        logic        g;
        logic        r;
        logic        s;
    } vec_t;

    typedef struct packed {
        logic [63:0] mant;
        logic        g;
        logic        r;
        logic        s;
        logic        sign;
        logic [3:0]  tag;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    // single-precision instance
    logic        in_valid = 1'b0, in_ready, in_sign = 1'b0;
    logic [23:0] in_mant = '0;
    logic [4:0]  in_nshift = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid, out_ready = 1'b1, out_sign, out_guard, out_round, out_sticky;
    logic [23:0] out_mant;
    logic [3:0]  out_tag;

    fp_align_rshift_pipe #(.MANT_W(24), .SHIFT_W(5), .TAG_W(4), .SPLIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_mant(in_mant), .in_nshift(in_nshift), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_mant(out_mant), .out_guard(out_guard), .out_round(out_round),
        .out_sticky(out_sticky), .out_tag(out_tag)
    );

    // double-precision instance
    logic        d_in_valid = 1'b0, d_in_ready, d_in_sign = 1'b0;
    logic [52:0] d_in_mant = '0;
    logic [5:0]  d_in_nshift = '0;
    logic [3:0]  d_in_tag = '0;
    logic        d_out_valid, d_out_ready = 1'b1, d_out_sign, d_out_guard, d_out_round, d_out_sticky;
    logic [52:0] d_out_mant;
    logic [3:0]  d_out_tag;

    fp_align_rshift_pipe #(.MANT_W(53), .SHIFT_W(6), .TAG_W(4), .SPLIT(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_sign(d_in_sign),
        .in_mant(d_in_mant), .in_nshift(d_in_nshift), .in_tag(d_in_tag),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_sign(d_out_sign),
        .out_mant(d_out_mant), .out_guard(d_out_guard), .out_round(d_out_round),
        .out_sticky(d_out_sticky), .out_tag(d_out_tag)
    );

    vec_t sv[16];
    vec_t dv[7];
    exp_t sb[$];
    exp_t d_sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic send(input int idx, input logic [3:0] tag);
        in_valid  = 1'b1;
        in_mant   = sv[idx].mant[23:0];
        in_nshift = sv[idx].n[4:0];
        in_tag    = tag;
        in_sign   = tag[0];
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{sv[idx].emant, sv[idx].g, sv[idx].r, sv[idx].s, tag[0], tag});
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic d_send(input int idx, input logic [3:0] tag);
        d_in_valid  = 1'b1;
        d_in_mant   = dv[idx].mant[52:0];
        d_in_nshift = dv[idx].n[5:0];
        d_in_tag    = tag;
        d_in_sign   = tag[0];
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (d_in_ready) begin
                d_sb.push_back('{dv[idx].emant, dv[idx].g, dv[idx].r, dv[idx].s, tag[0], tag});
                @(posedge clk); #1;
                d_in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        d_in_valid = 1'b0;
        chk("d_send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors: pop on every accepted output beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {60'd0, out_tag}, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mant",   {40'd0, out_mant}, e.mant);
                chk("guard",  {63'd0, out_guard}, {63'd0, e.g});
                chk("round",  {63'd0, out_round}, {63'd0, e.r});
                chk("sticky", {63'd0, out_sticky}, {63'd0, e.s});
                chk("sign",   {63'd0, out_sign}, {63'd0, e.sign});
                chk("tag",    {60'd0, out_tag}, {60'd0, e.tag});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d_out_valid && d_out_ready) begin
            if (d_sb.size() == 0) begin
                chk("d_unexpected_output", {60'd0, d_out_tag}, 64'hDEAD);
            end else begin
                exp_t e;
                e = d_sb.pop_front();
                chk("d_mant",   {11'd0, d_out_mant}, e.mant);
                chk("d_guard",  {63'd0, d_out_guard}, {63'd0, e.g});
                chk("d_round",  {63'd0, d_out_round}, {63'd0, e.r});
                chk("d_sticky", {63'd0, d_out_sticky}, {63'd0, e.s});
                chk("d_tag",    {60'd0, d_out_tag}, {60'd0, e.tag});
            end
        end
    end

    initial begin
        logic [23:0] hold_mant;
        logic [3:0]  hold_tag;

        // hand-computed single vectors: mant, n, exp mant, g, r, s
        sv[0]  = '{64'hC00001, 8'd0,  64'hC00001, 1'b0, 1'b0, 1'b0};
        sv[1]  = '{64'hC00001, 8'd1,  64'h600000, 1'b1, 1'b0, 1'b0};
        sv[2]  = '{64'hC00001, 8'd3,  64'h180000, 1'b0, 1'b0, 1'b1};
        sv[3]  = '{64'hC00001, 8'd25, 64'h0,      1'b0, 1'b1, 1'b1};
        sv[4]  = '{64'hC00001, 8'd26, 64'h0,      1'b0, 1'b0, 1'b1};
        sv[5]  = '{64'hC00001, 8'd31, 64'h0,      1'b0, 1'b0, 1'b1};
        sv[6]  = '{64'h000000, 8'd31, 64'h0,      1'b0, 1'b0, 1'b0};
        sv[7]  = '{64'hFFFFFF, 8'd2,  64'h3FFFFF, 1'b1, 1'b1, 1'b0};
        sv[8]  = '{64'h800000, 8'd24, 64'h0,      1'b1, 1'b0, 1'b0};
        sv[9]  = '{64'h800001, 8'd4,  64'h080000, 1'b0, 1'b0, 1'b1};
        sv[10] = '{64'hABCDEF, 8'd8,  64'h00ABCD, 1'b1, 1'b1, 1'b1};
        sv[11] = '{64'h123456, 8'd12, 64'h000123, 1'b0, 1'b1, 1'b1};
        sv[12] = '{64'h000003, 8'd2,  64'h0,      1'b1, 1'b1, 1'b0};
        sv[13] = '{64'h000001, 8'd1,  64'h0,      1'b1, 1'b0, 1'b0};
        sv[14] = '{64'h400000, 8'd16, 64'h000040, 1'b0, 1'b0, 1'b0};
        sv[15] = '{64'hFFFFFF, 8'd27, 64'h0,      1'b0, 1'b0, 1'b1};

        // double vectors (ext width 55: bit 52 of mant lands on ext bit 54)
        dv[0] = '{64'h0010_0000_0000_0000, 8'd54, 64'h0, 1'b0, 1'b1, 1'b0};
        dv[1] = '{64'h0010_0000_0000_0000, 8'd55, 64'h0, 1'b0, 1'b0, 1'b1};
        dv[2] = '{64'h0010_0000_0000_0000, 8'd63, 64'h0, 1'b0, 1'b0, 1'b1};
        dv[3] = '{64'h0010_0000_0000_0000, 8'd53, 64'h0, 1'b1, 1'b0, 1'b0};
        dv[4] = '{64'h0010_0000_0000_0001, 8'd1,  64'h0008_0000_0000_0000, 1'b1, 1'b0, 1'b0};
        dv[5] = '{64'h001F_FFFF_FFFF_FFFF, 8'd32, 64'h1F_FFFF, 1'b1, 1'b1, 1'b1};
        dv[6] = '{64'h0, 8'd63, 64'h0, 1'b0, 1'b0, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_mant",  {40'd0, out_mant}, 64'd0);
        chk("rst_grs",       {61'd0, out_guard, out_round, out_sticky}, 64'd0);
        chk("rst_sign_tag",  {59'd0, out_sign, out_tag}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);

        // latency: nothing after capture edge, result after the next one
        send(0, 4'd0);
        in_valid = 1'b0;
        chk("lat_edge1_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("lat_edge2_valid", {63'd0, out_valid}, 64'd1);
        idle(2);

        // directed vectors, one at a time then streaming
        for (int i = 1; i < 16; i++) send(i, 4'(i));
        idle(3);
        for (int i = 0; i < 8; i++) send(i, 4'(i));
        idle(3);

        // backpressure
        out_ready = 1'b0;
        send(10, 4'd10);
        send(11, 4'd11);
        in_valid = 1'b1;
        in_mant = sv[12].mant[23:0];
        in_nshift = sv[12].n[4:0];
        hold_mant = out_mant;
        hold_tag = out_tag;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready",  {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_mant_hold", {40'd0, out_mant}, {40'd0, hold_mant});
            chk("bp_tag_hold",  {60'd0, out_tag}, {60'd0, hold_tag});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(12, 4'd12);
        send(13, 4'd13);
        send(14, 4'd14);
        idle(4);

        // flush with both stages full; the offered operand must be refused
        out_ready = 1'b0;
        send(1, 4'd1);
        send(2, 4'd2);
        in_valid = 1'b1;
        in_mant = sv[3].mant[23:0];
        in_nshift = sv[3].n[4:0];
        in_tag = 4'd15;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        idle(3);
        chk("flush_stays_empty", {63'd0, out_valid}, 64'd0);
        send(7, 4'd7);
        in_valid = 1'b0;
        chk("post_flush_lat1", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("post_flush_lat2", {63'd0, out_valid}, 64'd1);
        idle(2);

        // double-width instance
        for (int i = 0; i < 7; i++) d_send(i, 4'(i));
        idle(4);

        // reset mid-operation
        out_ready = 1'b0;
        send(10, 4'd3);
        send(11, 4'd4);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_mant",  {40'd0, out_mant}, 64'd0);
        chk("mid_rst_grs",       {61'd0, out_guard, out_round, out_sticky}, 64'd0);
        chk("mid_rst_sign_tag",  {59'd0, out_sign, out_tag}, 64'd0);
        chk("mid_rst_in_ready",  {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        send(9, 4'd9);
        idle(2);

        // drain
        for (int c = 0; c < 50 && (sb.size() != 0 || d_sb.size() != 0); c++) @(posedge clk);
        chk("drain_pending", 64'(sb.size() + d_sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
